// File: rtl/wss_pkg.sv
// Shared definitions for the word store serializer.
//   state_t          : transfer FSM states (IDLE, WR_LO, WR_HI)
//   LO_LANE/HI_LANE  : byte lane indices within the 16-bit word
//   lane_byte()      : selects one byte lane of a 16-bit word
package wss_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  localparam logic LO_LANE = 1'b0;
  localparam logic HI_LANE = 1'b1;

  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
    return lane ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/wss_ack_timer.sv
// Per-byte acknowledge timeout counter.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : clear the count (takes priority over en_i)
//   en_i     : a write cycle passed without ack; count it
//   expire_o : this cycle is the LIMIT-th un-acked cycle
module wss_ack_timer #(
  parameter int LIMIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // cnt_q counts prior un-acked cycles, so LIMIT-1 here means this is the last allowed one.
  assign expire_o = en_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/word_store_serializer.sv
// Splits one 16-bit store into two byte writes on an 8-bit memory bus.
// A request is accepted via req_valid/req_ready in IDLE; the first byte is
// written at req_addr, the second at req_addr+1 (wrapping), each held until
// mem_ack. done pulses after the second byte, err pulses on ack timeout.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_addr, req_data    : byte address of first write, word to store
//   mem_we/addr/wdata     : byte write strobe, address, data (registered)
//   mem_ack               : memory accepted the current byte
//   done, err             : one-cycle completion / timeout-abort pulses
// Parameters: ADDR_W (address width), ACK_TIMEOUT (0 = wait forever).
// Build option: WSS_BIG_ENDIAN_EN swaps byte lanes (MSB at A, LSB at A+1).
module word_store_serializer
  import wss_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err
);

`ifdef WSS_BIG_ENDIAN_EN
  localparam logic FIRST_LANE = HI_LANE;
`else
  localparam logic FIRST_LANE = LO_LANE;
`endif
  localparam logic SECOND_LANE = ~FIRST_LANE;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic              ready_q, we_q, done_q, err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              expire;

  generate
    if (ACK_TIMEOUT > 0) begin : g_timer
      logic tmr_clr, tmr_en;
      // Fresh count for every byte: cleared while idle, on ack and on abort.
      assign tmr_clr = (state_q == IDLE) || mem_ack || expire;
      assign tmr_en  = (state_q != IDLE) && !mem_ack;
      wss_ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (expire)
      );
    end else begin : g_no_timer
      assign expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            data_q      <= req_data;
            state_q     <= WR_LO;
            ready_q     <= 1'b0;
            we_q        <= 1'b1;
            mem_addr_q  <= req_addr;
            mem_wdata_q <= lane_byte(req_data, FIRST_LANE);
          end
        end
        WR_LO: begin
          // Ack wins over a simultaneous timeout.
          if (mem_ack) begin
            state_q     <= WR_HI;
            mem_addr_q  <= addr_q + ADDR_W'(1);
            mem_wdata_q <= lane_byte(data_q, SECOND_LANE);
          end else if (expire) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        WR_HI: begin
          if (mem_ack) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end else if (expire) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_word_store_serializer.sv
// Directed bench for word_store_serializer: a table of word stores with
// hand-computed byte writes, plus sequences for timeout, reset abort and
// back-to-back acceptance. A second instance uses ACK_TIMEOUT=3.
module tb_word_store_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, mem_we, mem_ack, done, err;
  logic [15:0] req_addr, req_data, mem_addr;
  logic [7:0]  mem_wdata;

  logic        t_req_valid, t_req_ready, t_mem_we, t_mem_ack, t_done, t_err;
  logic [15:0] t_req_addr, t_req_data, t_mem_addr;
  logic [7:0]  t_mem_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_store_serializer #(.ADDR_W(16), .ACK_TIMEOUT(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .done(done), .err(err));

  word_store_serializer #(.ADDR_W(16), .ACK_TIMEOUT(3)) dut_to (
    .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_addr(t_req_addr), .req_data(t_req_data), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
    .mem_wdata(t_mem_wdata), .mem_ack(t_mem_ack), .done(t_done), .err(t_err));

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          delay;    // un-acked cycles before ack, per byte
    logic [15:0] a0;
    logic [7:0]  d0;
    logic [15:0] a1;
    logic [7:0]  d1;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in a cycle where req_ready is expected high; ends in the done cycle.
  task automatic run_xfer(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, " ready_idle"}, req_ready, 1);
    chk({tag, " we_idle"}, mem_we, 0);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_data  = v.data;
    mem_ack   = (v.delay == 0);
    step();
    req_valid = 1'b1;              // ignored outside IDLE
    req_addr  = ~v.addr;
    req_data  = ~v.data;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k <= v.delay; k++) begin
        chk({tag, $sformatf(" we_b%0d_c%0d", b, k)}, mem_we, 1);
        chk({tag, $sformatf(" addr_b%0d_c%0d", b, k)}, mem_addr, (b == 0) ? v.a0 : v.a1);
        chk({tag, $sformatf(" wdata_b%0d_c%0d", b, k)}, mem_wdata, (b == 0) ? v.d0 : v.d1);
        chk({tag, $sformatf(" ready_b%0d_c%0d", b, k)}, req_ready, 0);
        chk({tag, $sformatf(" done_b%0d_c%0d", b, k)}, done, 0);
        mem_ack = (k == v.delay);
        step();
        if (k == v.delay && b == 0) mem_ack = (v.delay == 0);
      end
    end
    req_valid = 1'b0;
    mem_ack   = 1'b1;                // ack in IDLE must be ignored
    chk({tag, " done"}, done, 1);
    chk({tag, " err"}, err, 0);
    chk({tag, " we_after"}, mem_we, 0);
    chk({tag, " ready_after"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef WSS_BIG_ENDIAN_EN
    vecs[0] = '{16'h0040, 16'hBEEF, 0, 16'h0040, 8'hBE, 16'h0041, 8'hEF};
    vecs[1] = '{16'hFFFF, 16'h1234, 0, 16'hFFFF, 8'h12, 16'h0000, 8'h34};
    vecs[2] = '{16'h1000, 16'hCAFE, 4, 16'h1000, 8'hCA, 16'h1001, 8'hFE};
    vecs[3] = '{16'h0010, 16'hA55A, 1, 16'h0010, 8'hA5, 16'h0011, 8'h5A};
`else
    vecs[0] = '{16'h0040, 16'hBEEF, 0, 16'h0040, 8'hEF, 16'h0041, 8'hBE};
    vecs[1] = '{16'hFFFF, 16'h1234, 0, 16'hFFFF, 8'h34, 16'h0000, 8'h12};
    vecs[2] = '{16'h1000, 16'hCAFE, 4, 16'h1000, 8'hFE, 16'h1001, 8'hCA};
    vecs[3] = '{16'h0010, 16'hA55A, 1, 16'h0010, 8'h5A, 16'h0011, 8'hA5};
`endif
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_data = '0; mem_ack = 1'b0;
    t_req_valid = 1'b0; t_req_addr = '0; t_req_data = '0; t_mem_ack = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst ready", req_ready, 1);
    chk("rst we", mem_we, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst t_ready", t_req_ready, 1);
    chk("rst t_we", t_mem_we, 0);

    // Back-to-back table: each transfer starts in the previous done cycle.
    for (int i = 0; i < 4; i++) run_xfer(vecs[i], i);
    step();
    chk("idle ack ignored we", mem_we, 0);
    chk("idle done low", done, 0);
    mem_ack = 1'b0;

    // Reset during WR_HI aborts the transfer.
    req_valid = 1'b1; req_addr = 16'h0100; req_data = 16'h5566;
    step();
    req_valid = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rstmid in_hi we", mem_we, 1);
    chk("rstmid in_hi addr", mem_addr, 16'h0101);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    chk("rstmid we", mem_we, 0);
    chk("rstmid ready", req_ready, 1);
    chk("rstmid done", done, 0);
    chk("rstmid err", err, 0);
    chk("rstmid addr", mem_addr, 0);
    step();
    chk("rstmid after we", mem_we, 0);
    chk("rstmid after done", done, 0);
    mem_ack = 1'b0;

    // Timeout instance (reset above also cleared it): no ack ever.
    t_req_valid = 1'b1; t_req_addr = 16'h0200; t_req_data = 16'h1111;
    step();
    t_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("to we_c%0d", k), t_mem_we, 1);
      chk($sformatf("to err_c%0d", k), t_err, 0);
      step();
    end
    chk("to err", t_err, 1);
    chk("to done", t_done, 0);
    chk("to we", t_mem_we, 0);
    chk("to ready", t_req_ready, 1);

    // New request accepted in the err cycle; ack on the limit cycle wins.
    t_req_valid = 1'b1; t_req_addr = 16'h0300; t_req_data = 16'h2233;
    step();
    t_req_valid = 1'b0;
    chk("to2 we", t_mem_we, 1);
    chk("to2 addr", t_mem_addr, 16'h0300);
`ifdef WSS_BIG_ENDIAN_EN
    chk("to2 wdata", t_mem_wdata, 8'h22);
`else
    chk("to2 wdata", t_mem_wdata, 8'h33);
`endif
    chk("to2 err_clear", t_err, 0);
    step();
    step();
    t_mem_ack = 1'b1;                // third WR_LO cycle: the limit
    step();
    t_mem_ack = 1'b0;
    chk("to2 lim err", t_err, 0);
    chk("to2 lim we", t_mem_we, 1);
    chk("to2 lim addr", t_mem_addr, 16'h0301);
    t_mem_ack = 1'b1;
    step();
    t_mem_ack = 1'b0;
    chk("to2 done", t_done, 1);
    chk("to2 done_err", t_err, 0);
    step();
    chk("to2 done_pulse", t_done, 0);

    // Timeout in WR_HI.
    t_req_valid = 1'b1; t_req_addr = 16'h0400; t_req_data = 16'h4455;
    step();
    t_req_valid = 1'b0;
    t_mem_ack = 1'b1;
    step();
    t_mem_ack = 1'b0;
    step();
    step();
    chk("to3 hi pre err", t_err, 0);
    step();
    chk("to3 hi err", t_err, 1);
    chk("to3 hi done", t_done, 0);
    chk("to3 hi we", t_mem_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
